axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 32, AXI byte address width.
REQ-003 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words (power of two); data width fixed at 32.
REQ-004 SHALL have ports (one clock; reset is asynchronous and active-high):
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous active-high reset
axi_awid  in  ID_W  write ID
axi_awaddr  in  ADDR_W  write start byte address
axi_awlen  in  8  beats minus one
axi_awsize  in  3  log2 bytes per beat
axi_awvalid  in  1  AW valid
axi_awready  out  1  AW ready
axi_wdata  in  32  write data
axi_wstrb  in  4  byte enables
axi_wlast  in  1  last write beat
axi_wvalid  in  1  W valid
axi_wready  out  1  W ready
axi_bid  out  ID_W  response ID (= captured awid)
axi_bresp  out  2  write response
axi_bvalid  out  1  B valid
axi_bready  in  1  B ready
axi_arid  in  ID_W  read ID
axi_araddr  in  ADDR_W  read start byte address
axi_arlen  in  8  beats minus one
axi_arsize  in  3  log2 bytes per beat
axi_arvalid  in  1  AR valid
axi_arready  out  1  AR ready
axi_rid  out  ID_W  read ID (= captured arid)
axi_rdata  out  32  read data
axi_rresp  out  2  read response
axi_rlast  out  1  last read beat
axi_rvalid  out  1  R valid
axi_rready  in  1  R ready

Function
REQ-005 SHALL act as AXI4 slave, INCR bursts only (burst/lock/cache/prot/qos not ported), one transaction outstanding at a time.
REQ-006 SHALL implement FSM IDLE, WDATA, WRESP, RDATA; axi_awready and axi_arready high only in IDLE.
REQ-007 IDLE: awvalid -> capture awid/awaddr/awlen/awsize, go WDATA; else arvalid -> capture ar fields, go RDATA; both asserted same cycle -> write wins, arready low that cycle.
REQ-008 WDATA: wready=1; each W handshake writes bytes where wstrb=1 to word addr[log2(DEPTH)+1:2]; address += 1<<size per beat; beat counter increments.
REQ-009 WDATA exits to WRESP on handshake with wlast=1; bresp=SLVERR(2'b10) if beat count != awlen+1, else per REQ-012.
REQ-010 WRESP: bvalid=1 from cycle after last W handshake, held with stable bid/bresp until bready; then IDLE.
REQ-011 RDATA: first rvalid exactly one cycle after AR handshake; memory read synchronous; rdata/rresp/rlast held stable while rvalid && !rready; next beat presented cycle after each handshake (full throughput when rready held high); rlast=1 on beat awlen index arlen; IDLE after last handshake.
REQ-012 Response per beat: address >= DEPTH*4 -> DECERR(2'b11), write dropped, rdata=0; size > 2 -> SLVERR, write dropped, rdata=0; otherwise OKAY(2'b00). Write bresp = worst error over burst (DECERR > SLVERR > OKAY).
REQ-013 Address arithmetic ADDR_W bits, wraps modulo 2^ADDR_W; no 4KB-boundary check.
REQ-014 Sub-word size (0,1): data lanes unshifted; slave relies on wstrb, returns full 32-bit word on reads.

Reset
REQ-015 rst high SHALL immediately force state IDLE, awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0, counters 0; in-flight transaction abandoned.
REQ-016 Memory contents SHALL NOT be cleared by reset; first cycle after rst deasserts awready=arready=1.

Verification
REQ-017 Single write 0x100 data 0xDEADBEEF strb 0xF, then read len 0 -> bresp OKAY, rdata 0xDEADBEEF, rlast=1, rvalid one cycle after AR.
REQ-018 Write burst len 3 at 0x40 data 1..4, read burst len 3 with rready toggling -> rdata 1,2,3,4 in order, rlast only beat 4, data stable under stall.
REQ-019 Partial write strb 0x3 data 0x0000AAAA over 0x11223344 -> read 0x1122AAAA.
REQ-020 awvalid and arvalid same cycle -> AW accepted first, AR accepted in IDLE after B handshake; ids returned matching.
REQ-021 Read at DEPTH*4 len 1 -> both beats rresp 2'b11, rdata 0; write len 1 with wlast on beat 1 -> bresp 2'b10.
REQ-022 rst asserted mid read burst (beat 2 of 4) -> rvalid 0 same cycle, IDLE after release, prior memory data intact on re-read.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 slave (INCR bursts, one transaction at a time) in front of a 32-bit single-port SRAM.
// Reads are synchronous: each R beat is registered the cycle after the AR/R handshake that requests it.
module axi_sram_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   axi_awid,
    input  logic [ADDR_W-1:0] axi_awaddr,
    input  logic [7:0]        axi_awlen,
    input  logic [2:0]        axi_awsize,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [31:0]       axi_wdata,
    input  logic [3:0]        axi_wstrb,
    input  logic              axi_wlast,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [ID_W-1:0]   axi_bid,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic [ID_W-1:0]   axi_arid,
    input  logic [ADDR_W-1:0] axi_araddr,
    input  logic [7:0]        axi_arlen,
    input  logic [2:0]        axi_arsize,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [ID_W-1:0]   axi_rid,
    output logic [31:0]       axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rlast,
    output logic              axi_rvalid,
    input  logic              axi_rready
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   MEM_BYTES = (ADDR_W + 1)'(DEPTH * 4);
    localparam logic [1:0]        OKAY      = 2'b00;
    localparam logic [1:0]        SLVERR    = 2'b10;
    localparam logic [1:0]        DECERR    = 2'b11;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t state_q, state_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [8:0]        cnt_q;
    logic [1:0]        err_q;

    function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] a, input logic [2:0] s);
        if ({1'b0, a} >= MEM_BYTES) return DECERR;
        if (s > 3'd2)               return SLVERR;
        return OKAY;
    endfunction

    logic aw_hs, ar_hs, w_hs, b_hs, r_hs;

    assign axi_awready = (state_q == IDLE) && !rst;
    assign axi_arready = (state_q == IDLE) && !axi_awvalid && !rst;
    assign axi_wready  = (state_q == WDATA);

    assign aw_hs = axi_awvalid && axi_awready;
    assign ar_hs = axi_arvalid && axi_arready;
    assign w_hs  = axi_wvalid  && axi_wready;
    assign b_hs  = axi_bvalid  && axi_bready;
    assign r_hs  = axi_rvalid  && axi_rready;

    // Write beat
    logic [1:0]        wr_resp, wr_worst;
    logic [AW-1:0]     wr_idx;
    logic              wr_en;

    assign wr_resp  = beat_resp(addr_q, size_q);
    assign wr_worst = (wr_resp > err_q) ? wr_resp : err_q;
    assign wr_idx   = addr_q[AW+1:2];
    assign wr_en    = w_hs && (wr_resp == OKAY);

    // Read beat: the first beat comes from the AR channel, later ones from the burst address register
    logic [ADDR_W-1:0] rd_addr, rd_next;
    logic [2:0]        rd_size;
    logic [1:0]        rd_resp;
    logic [AW-1:0]     rd_idx;

    assign rd_addr = (state_q == IDLE) ? axi_araddr : addr_q;
    assign rd_size = (state_q == IDLE) ? axi_arsize : size_q;
    assign rd_resp = beat_resp(rd_addr, rd_size);
    assign rd_idx  = rd_addr[AW+1:2];
    assign rd_next = rd_addr + (ADDR_W'(1) << rd_size);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb[b]) mem[wr_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = WDATA;
                else if (ar_hs) state_d = RDATA;
            end
            WDATA:   if (w_hs && axi_wlast) state_d = WRESP;
            WRESP:   if (b_hs)              state_d = IDLE;
            RDATA:   if (r_hs && axi_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            cnt_q      <= '0;
            err_q      <= OKAY;
            axi_bid    <= '0;
            axi_bresp  <= OKAY;
            axi_bvalid <= 1'b0;
            axi_rid    <= '0;
            axi_rdata  <= '0;
            axi_rresp  <= OKAY;
            axi_rlast  <= 1'b0;
            axi_rvalid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= axi_awaddr;
                        len_q   <= axi_awlen;
                        size_q  <= axi_awsize;
                        cnt_q   <= '0;
                        err_q   <= OKAY;
                        axi_bid <= axi_awid;
                    end else if (ar_hs) begin
                        addr_q     <= rd_next;
                        len_q      <= axi_arlen;
                        size_q     <= axi_arsize;
                        cnt_q      <= 9'd1;
                        axi_rid    <= axi_arid;
                        axi_rdata  <= (rd_resp == OKAY) ? mem[rd_idx] : '0;
                        axi_rresp  <= rd_resp;
                        axi_rlast  <= (axi_arlen == 8'd0);
                        axi_rvalid <= 1'b1;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        addr_q <= addr_q + (ADDR_W'(1) << size_q);
                        cnt_q  <= cnt_q + 9'd1;
                        err_q  <= wr_worst;
                        if (axi_wlast) begin
                            // cnt_q holds the beats before this one, so a correct burst ends at cnt_q == awlen
                            axi_bresp  <= (cnt_q != {1'b0, len_q}) ? SLVERR : wr_worst;
                            axi_bvalid <= 1'b1;
                        end
                    end
                end
                WRESP: begin
                    if (b_hs) axi_bvalid <= 1'b0;
                end
                RDATA: begin
                    if (r_hs) begin
                        if (axi_rlast) begin
                            axi_rvalid <= 1'b0;
                            axi_rlast  <= 1'b0;
                        end else begin
                            addr_q    <= rd_next;
                            cnt_q     <= cnt_q + 9'd1;
                            axi_rdata <= (rd_resp == OKAY) ? mem[rd_idx] : '0;
                            axi_rresp <= rd_resp;
                            axi_rlast <= (cnt_q == {1'b0, len_q});
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave: a word-array memory model predicts every B and R beat,
// a negedge monitor compares them each cycle they are valid, and directed cases pin literal values.
module tb_axi_sram_slave;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ID_W-1:0] axi_awid = '0, axi_arid = '0, axi_bid, axi_rid;
    logic [ADDR_W-1:0] axi_awaddr = '0, axi_araddr = '0;
    logic [7:0]  axi_awlen = '0, axi_arlen = '0;
    logic [2:0]  axi_awsize = '0, axi_arsize = '0;
    logic        axi_awvalid = 1'b0, axi_awready, axi_arvalid = 1'b0, axi_arready;
    logic [31:0] axi_wdata = '0, axi_rdata;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wlast = 1'b0, axi_wvalid = 1'b0, axi_wready;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready = 1'b0;
    logic        axi_rlast, axi_rvalid, axi_rready = 1'b0;

    always #5 clk = ~clk;

    axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [ID_W-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_mem [DEPTH];
    bexp_t bq[$];
    rexp_t rq[$];
    logic [31:0] wd[$];
    logic [3:0]  ws[$];
    logic [31:0] got_r[$];
    logic [1:0]  got_rr[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_resp(input int unsigned a, input int unsigned s);
        if (a >= DEPTH * 4) return 2'b11;
        if (s > 2)          return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_write(input logic [ID_W-1:0] id, input int unsigned a, input int unsigned len,
                               input int unsigned sz, input int nb);
        int unsigned cur = a;
        logic [1:0] worst = 2'b00;
        logic [1:0] r;
        bexp_t e;
        for (int i = 0; i < nb; i++) begin
            r = m_resp(cur, sz);
            if (r == 2'b00)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) exp_mem[cur / 4][8*b +: 8] = wd[i][8*b +: 8];
            if (r > worst) worst = r;
            cur = (cur + (1 << sz)) % (1 << ADDR_W);
        end
        e.id = id;
        e.resp = (nb != len + 1) ? 2'b10 : worst;
        bq.push_back(e);
    endtask

    task automatic model_read(input logic [ID_W-1:0] id, input int unsigned a, input int unsigned len,
                              input int unsigned sz);
        int unsigned cur = a;
        rexp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.id = id;
            e.resp = m_resp(cur, sz);
            e.data = (e.resp == 2'b00) ? exp_mem[cur / 4] : 32'h0;
            e.last = (i == int'(len));
            rq.push_back(e);
            cur = (cur + (1 << sz)) % (1 << ADDR_W);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (axi_bvalid) begin
                if (bq.size() == 0) chk("b_unexpected", 32'(axi_bvalid), 32'h0);
                else begin
                    chk("bid", 32'(axi_bid), 32'(bq[0].id));
                    chk("bresp", 32'(axi_bresp), 32'(bq[0].resp));
                    if (axi_bready) void'(bq.pop_front());
                end
            end
            if (axi_rvalid) begin
                if (rq.size() == 0) chk("r_unexpected", 32'(axi_rvalid), 32'h0);
                else begin
                    chk("rid", 32'(axi_rid), 32'(rq[0].id));
                    chk("rdata", axi_rdata, rq[0].data);
                    chk("rresp", 32'(axi_rresp), 32'(rq[0].resp));
                    chk("rlast", 32'(axi_rlast), 32'(rq[0].last));
                    if (axi_rready) void'(rq.pop_front());
                end
            end
        end
    end

    // ---------------- drivers (inputs change 1ns after posedge, handshakes judged at negedge) ----------------
    task automatic send_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input logic [7:0] len,
                           input logic [2:0] sz);
        int n = 0;
        axi_awid = id; axi_awaddr = a; axi_awlen = len; axi_awsize = sz; axi_awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!axi_awready && n < BUDGET);
        if (!axi_awready) chk("aw_timeout", 32'(n), 32'(BUDGET + 1));
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input logic [7:0] len,
                           input logic [2:0] sz);
        int n = 0;
        axi_arid = id; axi_araddr = a; axi_arlen = len; axi_arsize = sz; axi_arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!axi_arready && n < BUDGET);
        if (!axi_arready) chk("ar_timeout", 32'(n), 32'(BUDGET + 1));
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input int nb, input int gap_max);
        int n;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            axi_wdata = wd[i]; axi_wstrb = ws[i]; axi_wlast = (i == nb - 1); axi_wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!axi_wready && n < BUDGET);
            if (!axi_wready) chk("w_timeout", 32'(n), 32'(BUDGET + 1));
            @(posedge clk); #1;
            axi_wvalid = 1'b0;
        end
        axi_wlast = 1'b0;
    endtask

    task automatic recv_b(output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        chk("bvalid_timing", 32'(axi_bvalid), 32'h1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; @(negedge clk); end
        @(posedge clk); #1;
        axi_bready = 1'b1;
        do begin @(negedge clk); n++; end while (!axi_bvalid && n < BUDGET);
        if (!axi_bvalid) chk("b_timeout", 32'(n), 32'(BUDGET + 1));
        resp = axi_bresp;
        @(posedge clk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic recv_r(input int nb, input bit stall, output int cycles);
        int beats = 0;
        got_r.delete(); got_rr.delete();
        cycles = 0;
        while (beats < nb && cycles < BUDGET) begin
            axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (cycles == 0) chk("rvalid_timing", 32'(axi_rvalid), 32'h1);
            if (axi_rvalid && axi_rready) begin
                got_r.push_back(axi_rdata); got_rr.push_back(axi_rresp); beats++;
            end
            cycles++;
            @(posedge clk); #1;
        end
        axi_rready = 1'b0;
        if (beats < nb) chk("r_timeout", 32'(beats), 32'(nb));
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input int unsigned a, input int unsigned len,
                            input int unsigned sz, input int nb, input int gap_max, output logic [1:0] resp);
        model_write(id, a, len, sz, nb);
        send_aw(id, ADDR_W'(a), 8'(len), 3'(sz));
        send_w(nb, gap_max);
        recv_b(resp);
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input int unsigned a, input int unsigned len,
                           input int unsigned sz, input bit stall);
        int cyc;
        model_read(id, a, len, sz);
        send_ar(id, ADDR_W'(a), 8'(len), 3'(sz));
        recv_r(int'(len) + 1, stall, cyc);
        if (!stall) chk("r_throughput", 32'(cyc), 32'(len + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awready"}, 32'(axi_awready), 32'h0);
        chk({tag, "_arready"}, 32'(axi_arready), 32'h0);
        chk({tag, "_wready"},  32'(axi_wready),  32'h0);
        chk({tag, "_bvalid"},  32'(axi_bvalid),  32'h0);
        chk({tag, "_rvalid"},  32'(axi_rvalid),  32'h0);
        chk({tag, "_rlast"},   32'(axi_rlast),   32'h0);
        chk({tag, "_bresp"},   32'(axi_bresp),   32'h0);
        chk({tag, "_rresp"},   32'(axi_rresp),   32'h0);
        chk({tag, "_bid"},     32'(axi_bid),     32'h0);
        chk({tag, "_rid"},     32'(axi_rid),     32'h0);
        chk({tag, "_rdata"},   axi_rdata,        32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] br;
        int unsigned a, len, sz, nb;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_awready", 32'(axi_awready), 32'h1);
        chk("post_reset_arready", 32'(axi_arready), 32'h1);
        @(posedge clk); #1;

        // Fill the whole memory so every later read is predictable
        wd.delete(); ws.delete();
        for (int i = 0; i < DEPTH; i++) begin wd.push_back($urandom); ws.push_back(4'hF); end
        do_write(4'h1, 0, DEPTH - 1, 2, DEPTH, 0, br);
        chk("fill_bresp", 32'(br), 32'h0);

        // Single write then single read
        wd = '{32'hDEADBEEF}; ws = '{4'hF};
        do_write(4'h2, 'h100, 0, 2, 1, 1, br);
        chk("single_bresp", 32'(br), 32'h0);
        do_read(4'h2, 'h100, 0, 2, 0);
        chk("single_rdata", got_r[0], 32'hDEADBEEF);

        // Burst of four, read back with stalls
        wd = '{32'd1, 32'd2, 32'd3, 32'd4}; ws = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'h3, 'h40, 3, 2, 4, 2, br);
        do_read(4'h3, 'h40, 3, 2, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("burst_rdata%0d", i), got_r[i], 32'(i + 1));

        // Reset in the middle of a four-beat read (beat 2 presented and stalled)
        model_read(4'h6, 'h40, 3, 2);
        send_ar(4'h6, 16'h40, 8'd3, 3'd2);
        axi_rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        axi_rready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_rvalid", 32'(axi_rvalid), 32'h0);
        check_reset_outputs("rst_mid");
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_awready", 32'(axi_awready), 32'h1);
        chk("rst_mid_arready", 32'(axi_arready), 32'h1);
        @(posedge clk); #1;
        do_read(4'h6, 'h40, 3, 2, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("reread_rdata%0d", i), got_r[i], 32'(i + 1));

        // Partial-strobe write
        wd = '{32'h11223344}; ws = '{4'hF};
        do_write(4'h4, 'h80, 0, 2, 1, 0, br);
        wd = '{32'h0000AAAA}; ws = '{4'h3};
        do_write(4'h4, 'h80, 0, 2, 1, 0, br);
        do_read(4'h4, 'h80, 0, 2, 0);
        chk("partial_rdata", got_r[0], 32'h1122AAAA);

        // AW and AR presented together: write first, read only after B
        wd = '{32'hCAFE0005}; ws = '{4'hF};
        model_write(4'h5, 'h200, 0, 2, 1);
        model_read(4'h9, 'h200, 0, 2);
        axi_awid = 4'h5; axi_awaddr = 16'h200; axi_awlen = 8'd0; axi_awsize = 3'd2; axi_awvalid = 1'b1;
        axi_arid = 4'h9; axi_araddr = 16'h200; axi_arlen = 8'd0; axi_arsize = 3'd2; axi_arvalid = 1'b1;
        @(negedge clk);
        chk("collide_awready", 32'(axi_awready), 32'h1);
        chk("collide_arready", 32'(axi_arready), 32'h0);
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        send_w(1, 1);
        @(negedge clk);
        chk("collide_arready_wresp", 32'(axi_arready), 32'h0);
        @(posedge clk); #1;
        axi_bready = 1'b1;
        @(negedge clk);
        chk("collide_bvalid", 32'(axi_bvalid), 32'h1);
        @(posedge clk); #1;
        axi_bready = 1'b0;
        @(negedge clk);
        chk("collide_ar_after_b", 32'(axi_arready), 32'h1);
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        begin
            int cyc;
            recv_r(1, 0, cyc);
        end
        chk("collide_rdata", got_r[0], 32'hCAFE0005);

        // Out-of-range read, short write burst, oversize beats, address wrap
        do_read(4'h7, DEPTH * 4, 1, 2, 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("decerr_rresp%0d", i), 32'(got_rr[i]), 32'h3);
            chk($sformatf("decerr_rdata%0d", i), got_r[i], 32'h0);
        end
        wd = '{32'h55555555}; ws = '{4'hF};
        do_write(4'h8, 'h300, 1, 2, 1, 0, br);
        chk("short_burst_bresp", 32'(br), 32'h2);
        wd = '{32'h12345678}; ws = '{4'hF};
        do_write(4'hA, 'h10, 0, 3, 1, 0, br);
        chk("oversize_bresp", 32'(br), 32'h2);
        do_read(4'hA, 'h10, 0, 3, 0);
        chk("oversize_rresp", 32'(got_rr[0]), 32'h2);
        do_read(4'hB, 'hFFFC, 1, 2, 0);
        chk("wrap_rresp0", 32'(got_rr[0]), 32'h3);
        chk("wrap_rresp1", 32'(got_rr[1]), 32'h0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            len = $urandom_range(0, 7);
            sz  = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
            a   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16'hFFFF) : $urandom_range(0, DEPTH * 4 - 1);
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : len + 1;
                wd.delete(); ws.delete();
                for (int i = 0; i < int'(nb); i++) begin wd.push_back($urandom); ws.push_back(4'($urandom)); end
                do_write(4'($urandom), a, len, sz, int'(nb), 2, br);
            end else begin
                do_read(4'($urandom), a, len, sz, 1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(posedge clk);
        chk("b_queue_drained", 32'(bq.size()), 32'h0);
        chk("r_queue_drained", 32'(rq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
